// File: rtl/psum_ofifo_pkg.sv
// Shared constants and types for the partial-sum output FIFO.
package psum_ofifo_pkg;

    localparam int COL         = 8;
    localparam int PSUM_BW     = 16;
    localparam int OFIFO_DEPTH = 64;
    localparam int PTR_W       = $clog2(OFIFO_DEPTH) + 1;

    typedef logic signed [PSUM_BW-1:0] psum_t;

endpackage

// File: rtl/ofifo_lane.sv
// Single-column synchronous FIFO. Pointers carry one extra wrap bit to tell full from empty.
module ofifo_lane
    import psum_ofifo_pkg::*;
#(
    parameter int width = PSUM_BW,
    parameter int depth = OFIFO_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic             rd,
    input  logic [width-1:0] din,
    output logic [width-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic             drop
);

    localparam int ptr_w = $clog2(depth) + 1;

    logic [ptr_w-1:0] wptr;
    logic [ptr_w-1:0] rptr;
    logic [width-1:0] mem [depth];
    logic             push;
    logic             pop;

    assign empty = (wptr == rptr);
    assign full  = (wptr[ptr_w-1] != rptr[ptr_w-1]) &&
                   (wptr[ptr_w-2:0] == rptr[ptr_w-2:0]);
    assign push  = wr && !full;
    assign pop   = rd && !empty;
    assign drop  = wr && full;
    assign dout  = mem[rptr[ptr_w-2:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + ptr_w'(1);
            if (pop)  rptr <= rptr + ptr_w'(1);
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wptr[ptr_w-2:0]] <= din;
    end

endmodule

// File: rtl/psum_ofifo.sv
// Column-skew realigning output FIFO: one lane per array column, whole-row pops.
// Optional ReLU on the pop path is enabled by defining PSUM_OFIFO_RELU_EN.
module psum_ofifo
    import psum_ofifo_pkg::*;
#(
    parameter int col     = COL,
    parameter int psum_bw = PSUM_BW,
    parameter int depth   = OFIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [psum_bw*col-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [psum_bw*col-1:0] out,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_ready,
    output logic [col-1:0]         overflow
);

    logic [col-1:0]         empty;
    logic [col-1:0]         full;
    logic [col-1:0]         drop;
    logic [psum_bw*col-1:0] head;
    logic [psum_bw*col-1:0] row_next;
    logic                   pop;

    // All lanes pop together, so their read pointers never diverge.
    for (genvar c = 0; c < col; c++) begin : g_lane
        ofifo_lane #(
            .width (psum_bw),
            .depth (depth)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .wr    (wr[c]),
            .rd    (pop),
            .din   (in[c*psum_bw +: psum_bw]),
            .dout  (head[c*psum_bw +: psum_bw]),
            .empty (empty[c]),
            .full  (full[c]),
            .drop  (drop[c])
        );
    end

    assign o_valid = ~|empty;
    assign o_full  = |full;
    assign o_ready = ~o_full;
    assign pop     = rd && o_valid;

`ifdef PSUM_OFIFO_RELU_EN
    always_comb begin
        row_next = head;
        for (int c = 0; c < col; c++) begin
            if (head[c*psum_bw + psum_bw - 1]) row_next[c*psum_bw +: psum_bw] = '0;
        end
    end
`else
    assign row_next = head;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out      <= '0;
            overflow <= '0;
        end else begin
            if (pop) out <= row_next;
            overflow <= overflow | drop;
        end
    end

endmodule

// File: tb/tb_psum_ofifo.sv
// Self-checking bench for psum_ofifo: queue-per-lane reference model plus directed literal checks.
module tb_psum_ofifo;
    import psum_ofifo_pkg::*;

    localparam int W = PSUM_BW * COL;

    logic           clk   = 1'b0;
    logic           reset = 1'b0;
    logic [W-1:0]   in    = '0;
    logic [COL-1:0] wr    = '0;
    logic           rd    = 1'b0;
    logic [W-1:0]   out;
    logic           o_valid;
    logic           o_full;
    logic           o_ready;
    logic [COL-1:0] overflow;

    psum_ofifo dut (
        .clk      (clk),
        .reset    (reset),
        .in       (in),
        .wr       (wr),
        .rd       (rd),
        .out      (out),
        .o_valid  (o_valid),
        .o_full   (o_full),
        .o_ready  (o_ready),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Reference model: one queue of stored psums per column.
    logic [PSUM_BW-1:0] q [COL][$];
    logic [W-1:0]       exp_out = '0;
    logic [COL-1:0]     exp_ovf = '0;
    int                 n_checks = 0;
    int                 n_pass   = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [PSUM_BW-1:0] model_relu(input logic [PSUM_BW-1:0] v);
`ifdef PSUM_OFIFO_RELU_EN
        return v[PSUM_BW-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    function automatic bit model_valid();
        for (int c = 0; c < COL; c++) if (q[c].size() == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit model_full();
        for (int c = 0; c < COL; c++) if (q[c].size() == OFIFO_DEPTH) return 1'b1;
        return 1'b0;
    endfunction

    task automatic compare_all();
        check("out", out, exp_out);
        check("o_valid", W'(o_valid), W'(model_valid()));
        check("o_full", W'(o_full), W'(model_full()));
        check("o_ready", W'(o_ready), W'(!model_full()));
        check("overflow", W'(overflow), W'(exp_ovf));
    endtask

    // One clock edge with the currently driven inputs; model advances from pre-edge state.
    task automatic step();
        bit             pop;
        bit [COL-1:0]   full_pre;
        logic [COL-1:0] w;
        logic [W-1:0]   d;
        pop = rd && model_valid();
        w   = wr;
        d   = in;
        for (int c = 0; c < COL; c++) full_pre[c] = (q[c].size() == OFIFO_DEPTH);
        @(posedge clk);
        if (pop) begin
            for (int c = 0; c < COL; c++) exp_out[c*PSUM_BW +: PSUM_BW] = model_relu(q[c].pop_front());
        end
        for (int c = 0; c < COL; c++) begin
            if (w[c]) begin
                if (!full_pre[c]) q[c].push_back(d[c*PSUM_BW +: PSUM_BW]);
                else              exp_ovf[c] = 1'b1;
            end
        end
        #1;
        compare_all();
    endtask

    task automatic drive(input logic [COL-1:0] w, input logic [W-1:0] d, input logic r);
        wr = w;
        in = d;
        rd = r;
        step();
    endtask

    function automatic logic [W-1:0] rand_row();
        logic [W-1:0] d;
        for (int c = 0; c < COL; c++) d[c*PSUM_BW +: PSUM_BW] = PSUM_BW'($urandom);
        return d;
    endfunction

    // Reset asserted mid-cycle (asynchronous), held for two edges, released mid-cycle.
    task automatic apply_reset();
        reset = 1'b0;
        wr    = '0;
        rd    = 1'b0;
        #1;
        for (int c = 0; c < COL; c++) q[c].delete();
        exp_out = '0;
        exp_ovf = '0;
        check("rst_out", out, '0);
        check("rst_o_valid", W'(o_valid), W'(0));
        check("rst_o_ready", W'(o_ready), W'(1));
        check("rst_overflow", W'(overflow), W'(0));
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        reset = 1'b1;
    endtask

    initial begin
        logic [W-1:0] d;
        logic [W-1:0] skew_row;
        #2;
        apply_reset();

        // Diagonal fill: lane c written on cycle c.
        for (int c = 0; c < COL; c++) begin
            d = '0;
            d[c*PSUM_BW +: PSUM_BW] = PSUM_BW'(16'h0100 + c);
            drive(COL'(1) << c, d, 1'b0);
            check($sformatf("skew_valid_%0d", c), W'(o_valid), W'(c == COL - 1));
        end
        drive('0, rand_row(), 1'b1);
        skew_row = 128'h0107_0106_0105_0104_0103_0102_0101_0100;
        check("skew_row", out, skew_row);
        check("skew_drained", W'(o_valid), W'(0));

        // Mid-stream reset after five rows and one pop.
        for (int i = 0; i < 5; i++) drive('1, rand_row(), 1'b0);
        drive('0, rand_row(), 1'b1);
        apply_reset();
        drive('0, rand_row(), 1'b1);
        check("post_rst_empty", W'(o_valid), W'(0));
        drive('1, rand_row(), 1'b0);
        drive('0, rand_row(), 1'b1);

        // Fill to full, drop on lane 2, then pop a full lane while writing it.
        apply_reset();
        for (int i = 0; i < OFIFO_DEPTH; i++) drive('1, rand_row(), 1'b0);
        drive(8'h04, rand_row(), 1'b0);
        check("full_o_full", W'(o_full), W'(1));
        check("full_o_ready", W'(o_ready), W'(0));
        check("full_overflow", W'(overflow), W'(8'h04));
        drive(8'h01, rand_row(), 1'b1);
        check("pop_full_drop", W'(overflow), W'(8'h05));
        for (int i = 0; i < OFIFO_DEPTH - 1; i++) drive('0, rand_row(), 1'b1);
        check("full_drained", W'(o_valid), W'(0));

        // Read attempt while lane 3 is empty is ignored.
        apply_reset();
        drive(8'hF7, rand_row(), 1'b0);
        drive(8'hF7, rand_row(), 1'b0);
        drive('0, rand_row(), 1'b1);
        check("empty_rd_out", out, '0);
        drive(8'h08, rand_row(), 1'b0);
        drive(8'h08, rand_row(), 1'b1);
        drive('0, rand_row(), 1'b1);
        drive('0, rand_row(), 1'b1);

        // Sustained streaming past pointer wrap.
        apply_reset();
        for (int i = 0; i < 200; i++) drive('1, rand_row(), 1'b1);
        check("stream_no_ovf", W'(overflow), W'(0));

        // Random traffic with alternating fill-heavy and drain-heavy phases.
        for (int ph = 0; ph < 8; ph++) begin
            for (int i = 0; i < 150; i++) begin
                logic [COL-1:0] w;
                w = COL'($urandom);
                if (ph % 2 == 0) w = w | COL'($urandom);
                drive(w, rand_row(), ($urandom_range(0, 3) < ((ph % 2 == 0) ? 1 : 3)));
            end
        end

        // ReLU on the pop path.
        apply_reset();
        d = rand_row();
        d[0 +: PSUM_BW]       = 16'hFFF0;
        d[PSUM_BW +: PSUM_BW] = 16'h0005;
        drive('1, d, 1'b0);
        drive('0, rand_row(), 1'b1);
`ifdef PSUM_OFIFO_RELU_EN
        check("relu_lane0", W'(out[0 +: PSUM_BW]), W'(16'h0000));
`else
        check("relu_lane0", W'(out[0 +: PSUM_BW]), W'(16'hFFF0));
`endif
        check("relu_lane1", W'(out[PSUM_BW +: PSUM_BW]), W'(16'h0005));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/psum_ofifo.md
Name: psum_ofifo

Overview:
- Output FIFO directly downstream of the systolic MAC array.
- Captures each column's partial sum when that column's valid bit fires. Column valids arrive skewed in time because instructions propagate diagonally through the array.
- Re-aligns the columns into whole output rows and pops one full row (all col lanes) per read for the SFU/memory write-back stage.
- One independent FIFO per column, plus shared row-level read control and status.

Parameters:
- col, 8, number of array columns (FIFO lanes).
- psum_bw, 16, width of one partial sum (two's complement).
- depth, 64, entries per column FIFO; power of 2, at least 2.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low; low clears all state.
- in  input  psum_bw*col  psums from the array's out_s; lane c is bits [psum_bw*(c+1)-1 : psum_bw*c].
- wr  input  col  per-column write strobe, driven by the array's valid.
- rd  input  1  row pop request.
- out  output  psum_bw*col  registered popped row, same lane order as in.
- o_valid  output  1  every column FIFO is non-empty; a row is available.
- o_full  output  1  at least one column FIFO is full.
- o_ready  output  1  no column FIFO is full; equals ~o_full.
- overflow  output  col  sticky per-column flag: a write was dropped because that lane was full.

Behaviour:
- Reset (asynchronous, while low):
  - All read and write pointers = 0.
  - out = 0, overflow = 0.
  - o_valid = 0, o_full = 0, o_ready = 1.
  - Any contents in flight are discarded.
  - Release is synchronous to clk; the first write is accepted on the first rising edge after reset goes high.
- Pointers:
  - Each lane has a write pointer and a read pointer, each clog2(depth)+1 bits wide.
  - Empty: pointers equal.
  - Full: MSBs differ and the low bits are equal.
  - Wrap-around is natural modulo 2*depth.
- Write, per lane c, evaluated at each rising edge:
  - If wr[c]=1 and lane c is not full (pre-edge state): store in lane c at wptr[c] and increment wptr[c].
  - If wr[c]=1 and lane c is full: drop the data, leave wptr unchanged, set overflow[c]=1. overflow clears only on reset.
- Read, evaluated at each rising edge:
  - If rd=1 and o_valid=1 (pre-edge state): load out with the head entry of every lane in the same edge, and increment all rptr.
  - If rd=1 and o_valid=0: ignored. out holds, pointers unchanged, no error flag.
  - Latency: out reflects the popped row in the cycle after the accepting edge. out holds between pops.
- Simultaneous write and read on one lane: both take effect.
  - A full lane that is being popped in the same cycle still refuses the write, because full is judged on pre-edge state.
  - An empty lane written in the same cycle is not readable until the next cycle. There is no bypass, and o_valid comes from registered counts.
- Status:
  - o_valid, o_full and o_ready are combinational from the pointers, which are registered, so they are glitch-free at cycle granularity.
  - All three are updated the cycle after any pointer change.
- Skew tolerance: lanes may run up to depth entries ahead of each other. o_valid waits for the slowest lane.

Optional Feature:
- Macro: PSUM_OFIFO_RELU_EN.
- Defined: each lane is passed through ReLU on the pop path before out is registered. A negative value (MSB=1) becomes 0; all other values pass unchanged. FIFO contents are stored raw.
- Undefined: out is the raw stored psum. No extra logic is generated.

Decomposition:
- Shared package psum_ofifo_pkg holds:
  - default constants COL=8, PSUM_BW=16, OFIFO_DEPTH=64;
  - localparam PTR_W = clog2(depth)+1;
  - typedef psum_t as a signed [psum_bw-1:0].
- One sub-module, ofifo_lane: a single-column synchronous FIFO.
  - Ports: wr, rd, din, dout, empty, full, drop.
  - Instantiated col times by a generate loop.
  - The top level holds row read control, the out register, ReLU and the overflow flags.

Test Plan:
- Reset check: hold reset low mid-stream after 5 rows are written -> out=0, o_valid=0, o_ready=1, overflow=0; after release the FIFO behaves as empty.
- Skewed fill: write lane c with value 16'h0100+c, with wr[c] asserted on cycle c (a diagonal) -> o_valid rises only the cycle after lane 7 is written; rd -> the next-cycle out lanes are 0x0100..0x0107.
- Full and overflow: write 64 rows to all lanes, then one more with wr=8'h04 -> o_full=1, o_ready=0, overflow=8'h04; the popped rows are exactly the first 64 in order.
- Empty read: rd=1 with lane 3 empty and the others holding data -> out unchanged, no pointer moves, and the later pop returns the correct aligned row.
- Simultaneous traffic and wrap: sustained wr=8'hFF with rd=1 every cycle for 200 cycles (past wrap) -> output sequence matches input with 1 row of fill latency and no overflow; a lane that is full while being popped still drops its same-cycle write.
- With PSUM_OFIFO_RELU_EN defined: lanes 16'hFFF0 and 16'h0005 -> out lanes 0 and 5. Without it -> 16'hFFF0 and 5.
